// File: rtl/fetch_queue_stage_if.sv
// fetch_queue_stage_if: bundles the redirect input, instruction-memory read port
// and decode-side valid/ready handshake of the fetch queue stage.
// master = the fetch stage itself, slave = the surrounding core (memory + decode).
interface fetch_queue_stage_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
);
  // Redirect from execute.
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  // Synchronous-read instruction memory port.
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [XLEN-1:0]   imem_rdata;
  // Decode handshake, driven from the queue head.
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_instr;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_pcplus4;

  modport master (
    input  redirect, redirect_pc, imem_rdata, out_ready,
    output imem_en, imem_addr, out_valid, out_instr, out_pc, out_pcplus4
  );

  modport slave (
    output redirect, redirect_pc, imem_rdata, out_ready,
    input  imem_en, imem_addr, out_valid, out_instr, out_pc, out_pcplus4
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: owns the PC, issues word reads to a 1-cycle synchronous
// instruction memory and buffers {instr, pc, pc+4} in a DEPTH-entry FIFO that
// feeds decode over valid/ready. A redirect flushes the queue and squashes the
// read in flight. Issue is credit based (queued + in-flight < DEPTH), so a
// returning word always finds a free slot.
// Optional: define FETCH_PERF_CNT_EN to add the perf_fetched / perf_squashed
// counters; without it the block has no counter ports or logic.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              ADDR_W   = 12,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst,
  fetch_queue_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Fetch-side state.
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  req_pc;
  logic             inflight;

  // Queue state; pointers wrap naturally because DEPTH is a power of two.
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  q_instr   [DEPTH];
  logic [XLEN-1:0]  q_pc      [DEPTH];
  logic [XLEN-1:0]  q_pcplus4 [DEPTH];

  // Per-cycle decisions.
  logic [CNT_W-1:0] credits;
  logic             issue;
  logic             push;
  logic             pop;

  // The low two bits of a redirect target are dropped: fetch is word aligned.
  logic [1:0] unused_redirect_lsbs;
  assign unused_redirect_lsbs = bus.redirect_pc[1:0];

  // Decide issue / push / pop; a redirect suppresses all three.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    credits = count + CNT_W'(inflight);
    issue   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    if (!bus.redirect) begin
      issue = (credits < DEPTH_C);
      push  = inflight;
      pop   = (count != '0) && bus.out_ready;
    end
  end

  // Reset is folded into the enable so the memory sees no read while held in reset.
  assign bus.imem_en   = issue && !rst;
  assign bus.imem_addr = pc[ADDR_W+1:2];

  // PC, in-flight flag and the PC of the outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (bus.redirect) begin
      pc       <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc     <= pc + XLEN'(4);
        req_pc <= pc;
      end
    end
  end

  // Queue pointers and occupancy; a redirect flushes back to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage: write the returning word at the tail.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the entries are reset because out_* read the head directly and must be 0 out of reset.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i]   <= '0;
        q_pc[i]      <= '0;
        q_pcplus4[i] <= '0;
      end
    end else if (push) begin
      q_instr[tail]   <= bus.imem_rdata;
      q_pc[tail]      <= req_pc;
      q_pcplus4[tail] <= req_pc + XLEN'(4);
    end
  end

  // Decode sees only registered head state: no path from imem_rdata to out_*.
  assign bus.out_valid   = (count != '0);
  assign bus.out_instr   = q_instr[head];
  assign bus.out_pc      = q_pc[head];
  assign bus.out_pcplus4 = q_pcplus4[head];

`ifdef FETCH_PERF_CNT_EN
  // Count accepted instructions and work thrown away by redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else if (bus.redirect) begin
      perf_squashed <= perf_squashed + 32'(count) + 32'(inflight);
    end else if (pop) begin
      perf_fetched  <= perf_fetched + 32'd1;
    end
  end
`endif

endmodule
